sub_arbiter: RTL
================

Name: sub_arbiter

Overview:
Shares one 16-bit saturating subtract unit (`sub`) between two requesters and sequences each operation through a 3-state controller.
- Arbitration is round-robin between the two requesters.
- Operands are latched at accept and result/flags are registered.
- The response is presented on a valid/ready port.
- The architectural Z/N/V flag register is updated when the response is consumed.
- Sits between the decode/issue logic and the execute-stage subtract unit.

Parameters:
WIDTH, 16, datapath width; only 16 is supported because `sub` is fixed at 16 bits.
PRIORITY_INIT, 0, requester that wins the first contested grant after reset (0 or 1).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  16  requester 0 minuend
req0_b  in  16  requester 0 subtrahend
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 operation accepted this cycle
req1_a  in  16  requester 1 minuend
req1_b  in  16  requester 1 subtrahend
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that owns the response
rsp_out  out  16  saturated difference
rsp_zr  out  1  result zero
rsp_neg  out  1  result negative
rsp_ov  out  1  saturation occurred
flag_zr  out  1  architectural zero flag
flag_neg  out  1  architectural negative flag
flag_ov  out  1  architectural overflow flag
busy  out  1  state != IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE
  - rsp_valid = 0, rsp_id = 0, rsp_out = 0, rsp_zr = 0, rsp_neg = 0, rsp_ov = 0
  - flag_zr = 0, flag_neg = 0, flag_ov = 0
  - operand registers = 0
  - last-grant pointer = ~PRIORITY_INIT
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule:
    - only reqN_valid high -> grant N
    - both high -> grant the requester opposite the last-grant pointer
  - reqN_ready is combinational, asserted only in IDLE and only for the granted requester. At most one ready is high per cycle.
  - On handshake (valid & ready):
    - latch reqN_a and reqN_b into the operand registers
    - latch N into the id register
    - set last-grant pointer = N
    - go to EXEC
  - With no valid, remain in IDLE.
- EXEC:
  - The latched operands drive the `sub` instance.
  - At the end of the cycle, register sub outputs into rsp_out, rsp_zr, rsp_neg and rsp_ov; set rsp_valid = 1; go to RESP.
  - Arithmetic is defined entirely by `sub`:
    - positive overflow -> 0x7FFF, ov = 1, neg = 0, zr = 0
    - negative overflow -> 0x8000, ov = 1, neg = 1, zr = 0
    - otherwise -> wrap difference, ov = 0, neg = bit15, zr = (diff == 0)
- RESP:
  - rsp_valid = 1, and all rsp_* outputs are held stable until rsp_ready is high.
  - On rsp_valid & rsp_ready:
    - copy rsp_zr, rsp_neg and rsp_ov into flag_zr, flag_neg and flag_ov
    - clear rsp_valid next cycle
    - go to IDLE
  - Both reqN_ready stay low in EXEC and RESP.
- Latency and throughput:
  - accept in cycle T -> rsp_valid first high in cycle T+2
  - flags reflect the result in the cycle after the response handshake
  - maximum throughput is one operation per 3 cycles
- Requester rules:
  - A requester holds valid and operands stable until it sees ready.
  - Changing operands while valid is low is don't-care.
  - Dropping valid before ready is legal, and no operation is issued for it.
- Flags: change only on a response handshake; never in IDLE or EXEC.
- Reset mid-operation (EXEC or RESP): the pending operation is discarded with no response and no flag update, and all reset values above are restored next cycle.
- Simultaneous events:
  - A new request arriving during RESP is not accepted until IDLE.
  - rsp_ready high during IDLE or EXEC is ignored.
- Pointer: updates only on an accept handshake, never on reset release alone.

Test Plan:
1. Basic subtract: req0 a=0x0005 b=0x0003, rsp_ready=1, accept at cycle T.
   -> rsp_valid at T+2, rsp_id=0, rsp_out=0x0002, zr/neg/ov=0/0/0; flags 0/0/0 at T+3.
2. Positive saturation: req1 a=0x7FFF b=0xFFFF.
   -> rsp_out=0x7FFF, ov=1, neg=0, zr=0, rsp_id=1; flag_ov=1 after handshake.
3. Negative saturation and zero:
   - a=0x8000 b=0x0001 -> rsp_out=0x8000, ov=1, neg=1.
   - then a=0x1234 b=0x1234 -> rsp_out=0x0000, zr=1, ov=0; flag_ov returns to 0.
4. Round-robin: PRIORITY_INIT=0, both valid continuously, rsp_ready=1, distinct operands.
   -> grants and rsp_id sequence 0,1,0,1; accepts 3 cycles apart; never both ready high.
5. Backpressure: one op, rsp_ready held low 5 cycles.
   -> rsp_valid and rsp_* values held constant; req0_ready/req1_ready stay low; flags unchanged until the cycle after rsp_ready rises.
6. Reset mid-op: assert rst for one cycle while in EXEC.
   -> next cycle state IDLE, rsp_valid=0, flags 0, busy=0, no response ever emitted; next contested grant goes to PRIORITY_INIT.

Source files
------------

// File: rtl/sub_arbiter.sv
// Two-requester front end for a shared 16-bit saturating subtract unit.
// A requester is accepted in IDLE. Its operands run through `sub` in EXEC.
// The registered result is offered in RESP until the consumer takes it.
// Taking the response also loads the Z/N/V flag register.

// Signed 16-bit subtract. The result clamps to the signed range on overflow.
module sub (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y,
    output logic        zr,
    output logic        neg,
    output logic        ov
);
    logic [15:0] diff;
    logic        ovf;

    // Wrap difference, then clamp when the operand signs differ and the sign flipped
    always_comb begin
        diff = a - b;
        ovf  = (a[15] ^ b[15]) & (diff[15] ^ a[15]);
        if (ovf) begin
            y = a[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            y = diff;
        end
        ov  = ovf;
        neg = y[15];
        zr  = (y == 16'h0000);
    end
endmodule

module sub_arbiter #(
    parameter int WIDTH         = 16,
    parameter int PRIORITY_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zr,
    output logic             rsp_neg,
    output logic             rsp_ov,
    output logic             flag_zr,
    output logic             flag_neg,
    output logic             flag_ov,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // After reset the pointer names the requester that does NOT get the first contested grant
    localparam logic LAST_INIT = (PRIORITY_INIT == 0) ? 1'b1 : 1'b0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;
    logic             last_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_out_q;
    logic             rsp_zr_q, rsp_neg_q, rsp_ov_q;
    logic             flag_zr_q, flag_neg_q, flag_ov_q;

    logic             grant1;
    logic             accept;
    logic             rsp_fire;
    logic [15:0]      sub_y;
    logic             sub_zr, sub_neg, sub_ov;

    sub u_sub (
        .a   (a_q),
        .b   (b_q),
        .y   (sub_y),
        .zr  (sub_zr),
        .neg (sub_neg),
        .ov  (sub_ov)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req0_valid || req1_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: round-robin grant and handshake strobes
    always_comb begin
        // Requester 1 wins when it is alone, or when both ask and requester 0 went last
        grant1     = req1_valid & (~req0_valid | ~last_q);
        req0_ready = (state_q == S_IDLE) & req0_valid & ~grant1;
        req1_ready = (state_q == S_IDLE) & grant1;
        accept     = (state_q == S_IDLE) & (req0_valid | req1_valid);
        rsp_fire   = (state_q == S_RESP) & rsp_ready;
        busy       = (state_q != S_IDLE);
    end

    // Operand, id and pointer capture on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
            last_q <= LAST_INIT;
        end else if (accept) begin
            a_q    <= grant1 ? req1_a : req0_a;
            b_q    <= grant1 ? req1_b : req0_b;
            id_q   <= grant1;
            last_q <= grant1;
        end
    end

    // Result registers: loaded at the end of EXEC and held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_zr_q    <= 1'b0;
            rsp_neg_q   <= 1'b0;
            rsp_ov_q    <= 1'b0;
        end else if (state_q == S_EXEC) begin
            rsp_valid_q <= 1'b1;
            rsp_out_q   <= sub_y;
            rsp_zr_q    <= sub_zr;
            rsp_neg_q   <= sub_neg;
            rsp_ov_q    <= sub_ov;
        end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Architectural flags follow the response only when it is consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_zr_q  <= 1'b0;
            flag_neg_q <= 1'b0;
            flag_ov_q  <= 1'b0;
        end else if (rsp_fire) begin
            flag_zr_q  <= rsp_zr_q;
            flag_neg_q <= rsp_neg_q;
            flag_ov_q  <= rsp_ov_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_zr    = rsp_zr_q;
    assign rsp_neg   = rsp_neg_q;
    assign rsp_ov    = rsp_ov_q;
    assign flag_zr   = flag_zr_q;
    assign flag_neg  = flag_neg_q;
    assign flag_ov   = flag_ov_q;
endmodule
